vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA/raster timing generator for the graphics pipeline, successor to the fixed 640x480 timing block. It derives a pixel-rate enable from the system clock by a configurable integer divider. It produces horizontal and vertical counters, sync pulses of configurable polarity, and a visible-area flag. It also provides line and frame start strobes and a one-pixel-early fetch coordinate, so the snake/board renderer can read a synchronous RAM without extra latency.

## Interface
- CLK_DIV, 4: system clocks per pixel, ≥1 (100 MHz → 25 MHz).
- H_VISIBLE / H_FRONT / H_SYNC / H_BACK, 640 / 16 / 96 / 48: horizontal segment lengths in pixels.
- V_VISIBLE / V_FRONT / V_SYNC / V_BACK, 480 / 10 / 2 / 33: vertical segment lengths in lines.
- H_SYNC_POL / V_SYNC_POL, 0 / 0: active level of each sync pulse.
- CNT_W, 10: counter width. H_TOTAL and V_TOTAL must each be ≤ 2^CNT_W; any violation is an elaboration error.
- i_clk  in  1  system clock; the only clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  run enable; low holds the block in the reset state, synchronously.
- o_pix_tick  out  1  one-i_clk pulse per pixel period.
- o_hcount / o_vcount  out  CNT_W  registered pixel coordinates.
- o_hsync / o_vsync  out  1  sync outputs at the configured polarity.
- o_video_on  out  1  high when (o_hcount, o_vcount) lies in the visible area.
- o_line_start / o_frame_start  out  1  one-i_clk strobes.
- o_fetch_x / o_fetch_y  out  CNT_W  coordinate one pixel ahead of o_hcount/o_vcount.
- o_fetch_valid  out  1  fetch coordinate is inside the visible area.

## Operation
- Derived totals:
  - H_TOTAL is the sum of the four H segments.
  - V_TOTAL is the sum of the four V segments.
- Divider:
  - r_div counts 0..CLK_DIV-1 and wraps.
  - Tick is high when r_div == CLK_DIV-1.
  - With CLK_DIV=1, tick is high on every cycle.
- Raw counters r_h and r_v, advanced on tick:
  - r_h wraps at H_TOTAL-1.
  - r_v increments only when r_h wraps, and itself wraps at V_TOTAL-1.
- Output stage, loaded on tick from the pre-increment r_h/r_v:
  - o_hcount = r_h and o_vcount = r_v.
  - o_video_on = (r_h < H_VISIBLE) && (r_v < V_VISIBLE).
  - o_hsync = H_SYNC_POL when H_VISIBLE+H_FRONT ≤ r_h < H_VISIBLE+H_FRONT+H_SYNC; otherwise ~H_SYNC_POL.
  - o_vsync follows the same rule with the V parameters and r_v.
- Fetch outputs:
  - o_fetch_x = r_h and o_fetch_y = r_v, taken directly from the registers.
  - o_fetch_valid uses the same visible test applied to r_h/r_v.
  - Result: fetch leads the output stage by exactly one pixel period, including across line and frame wrap.
- Strobes:
  - o_line_start is high for the single i_clk cycle after the tick edge that loads o_hcount=0.
  - o_frame_start is high in that same cycle only if o_vcount is also loaded as 0.
- Enable:
  - i_en low clears r_div, r_h, r_v and every output to reset values on the next edge.
  - When i_en rises, the first tick occurs CLK_DIV cycles later.
- Reset values (async reset and i_en low alike):
  - r_div, r_h, r_v, o_hcount, o_vcount, o_fetch_x/y = 0.
  - o_pix_tick, o_video_on, o_fetch_valid, o_line_start, o_frame_start = 0.
  - o_hsync = ~H_SYNC_POL and o_vsync = ~V_SYNC_POL.
  - Reset may arrive mid-line or mid-sync pulse; outputs go to these values immediately.

## Timing
- o_pix_tick is registered: it is high in the cycle after r_div reaches CLK_DIV-1, aligned with the cycle in which the output-stage values first appear.
- The output stage lags the raw counters by one pixel. Fetch-to-display latency is one pixel period, which suits a 1-cycle synchronous RAM when CLK_DIV ≥ 2.
- Per-frame cycle counts:
  - Frame period = H_TOTAL·V_TOTAL·CLK_DIV i_clk cycles.
  - Line period = H_TOTAL·CLK_DIV cycles.
  - Hsync width = H_SYNC·CLK_DIV cycles; vsync width = V_SYNC·H_TOTAL·CLK_DIV cycles.
- Sync edges never glitch; each output changes only on a tick edge.

## Test plan
- Reset and enable:
  - Stimulus: defaults; hold i_rst_n low, then release with i_en=1.
  - Response: all outputs at reset values, syncs at 1; first o_pix_tick on cycle 4; o_line_start and o_frame_start pulse once at that first load.
- Horizontal timing:
  - Stimulus: defaults, run one line.
  - Response: o_hsync low exactly while o_hcount is 656..751 (384 i_clk cycles); o_video_on high while o_hcount is 0..639; line period 3200 cycles.
- Vertical and frame timing:
  - Stimulus: defaults, run two frames.
  - Response: o_vsync low for o_vcount 490..491; o_frame_start spacing exactly 1,680,000 cycles.
- Small geometry, full-frame check:
  - Stimulus: CLK_DIV=1, H 8/1/2/1, V 4/1/1/1, H_SYNC_POL=1.
  - Response: tick every cycle; hsync high at o_hcount 9..10; frame = 84 cycles; o_fetch_x equals o_hcount+1 mod 12 on every cycle.
- Enable drop mid-operation:
  - Stimulus: drop i_en at o_hcount=700 (inside hsync), then reassert.
  - Response: next edge all outputs at reset values with hsync inactive; after reassert, first tick 4 cycles later with o_hcount=0, o_vcount=0, o_frame_start pulsed.
- Async reset mid-frame:
  - Stimulus: assert i_rst_n low in the middle of vsync.
  - Response: outputs clear without waiting for a clock edge; sequence restarts identically to the reset-and-enable scenario.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator. A system-clock divider produces the
//   pixel-rate enable; raw h/v counters advance on it. A registered output
//   stage presents the counters one pixel late, along with the sync pulses
//   and the visible-area flag. The raw counters are also exposed as a
//   one-pixel-early fetch coordinate, so a 1-cycle synchronous RAM can be
//   read in time for display.
//
// Ports
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_en           run enable; low clears everything on the next edge
//   o_pix_tick     one-cycle pulse per pixel period
//   o_hcount/o_vcount     displayed pixel coordinate
//   o_hsync/o_vsync       sync pulses at the configured polarity
//   o_video_on     displayed coordinate is inside the visible area
//   o_line_start/o_frame_start  one-cycle strobes at pixel (0, y) / (0, 0)
//   o_fetch_x/o_fetch_y   coordinate one pixel ahead of the display
//   o_fetch_valid  fetch coordinate is inside the visible area
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CNT_W      = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic             o_pix_tick,
  output logic [CNT_W-1:0] o_hcount,
  output logic [CNT_W-1:0] o_vcount,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_video_on,
  output logic             o_line_start,
  output logic             o_frame_start,
  output logic [CNT_W-1:0] o_fetch_x,
  output logic [CNT_W-1:0] o_fetch_y,
  output logic             o_fetch_valid
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW1     = CNT_W + 1;

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (longint'(H_TOTAL) > (64'd1 << CNT_W)) begin : g_bad_h
      $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (longint'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_bad_v
      $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end
  endgenerate

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  // Window bounds carry one extra bit so a segment ending exactly at
  // 2^CNT_W still compares correctly.
  localparam logic [CNT_W:0]   H_VIS    = CW1'(H_VISIBLE);
  localparam logic [CNT_W:0]   V_VIS    = CW1'(V_VISIBLE);
  localparam logic [CNT_W:0]   H_SS     = CW1'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W:0]   H_SE     = CW1'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0]   V_SS     = CW1'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W:0]   V_SE     = CW1'(V_VISIBLE + V_FRONT + V_SYNC);

  function automatic logic is_visible(logic [CNT_W-1:0] h, logic [CNT_W-1:0] v);
    return ({1'b0, h} < H_VIS) && ({1'b0, v} < V_VIS);
  endfunction

  function automatic logic sync_level(logic [CNT_W-1:0] pos, logic [CNT_W:0] lo,
                                      logic [CNT_W:0] hi, logic pol);
    return (({1'b0, pos} >= lo) && ({1'b0, pos} < hi)) ? pol : ~pol;
  endfunction

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             r_active;
  logic             tick_p0;
  logic             h_wrap_p0;
  logic             v_wrap_p0;

  // Stage p0: divider and raw counters
  assign tick_p0   = (r_div == DIV_LAST);
  assign h_wrap_p0 = (r_h == H_LAST);
  assign v_wrap_p0 = (r_v == V_LAST);

  // The fetch coordinate is the raw counter itself; r_active keeps the
  // valid flag low while held in reset even though (0,0) is visible.
  assign o_fetch_x     = r_h;
  assign o_fetch_y     = r_v;
  assign o_fetch_valid = r_active & is_visible(r_h, r_v);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div         <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_active      <= 1'b0;
      o_pix_tick    <= 1'b0;
      o_hcount      <= '0;
      o_vcount      <= '0;
      o_hsync       <= ~H_SYNC_POL;
      o_vsync       <= ~V_SYNC_POL;
      o_video_on    <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else if (!i_en) begin
      r_div         <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_active      <= 1'b0;
      o_pix_tick    <= 1'b0;
      o_hcount      <= '0;
      o_vcount      <= '0;
      o_hsync       <= ~H_SYNC_POL;
      o_vsync       <= ~V_SYNC_POL;
      o_video_on    <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      r_active      <= 1'b1;
      // Stage p1: output registers, loaded from the pre-increment counters
      o_pix_tick    <= tick_p0;
      o_line_start  <= tick_p0 && (r_h == '0);
      o_frame_start <= tick_p0 && (r_h == '0) && (r_v == '0);
      if (tick_p0) begin
        r_div      <= '0;
        r_h        <= h_wrap_p0 ? '0 : r_h + 1'b1;
        if (h_wrap_p0) begin
          r_v <= v_wrap_p0 ? '0 : r_v + 1'b1;
        end
        o_hcount   <= r_h;
        o_vcount   <= r_v;
        o_video_on <= is_visible(r_h, r_v);
        o_hsync    <= sync_level(r_h, H_SS, H_SE, H_SYNC_POL);
        o_vsync    <= sync_level(r_v, V_SS, V_SE, V_SYNC_POL);
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic       tick;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       vid;
    logic       ls;
    logic       fs;
    logic [9:0] fx;
    logic [9:0] fy;
    logic       fv;
  } obs_t;

  typedef struct {
    int div, hv, hf, hs, hb, vv, vf, vs, vb;
    bit hp, vp;
  } geom_t;

  typedef struct {
    int cyc;
    int h, v, fx, fy;
    bit tick, hs, vs, vid, ls, fs, fv;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- DUT A: default 640x480, CLK_DIV=4 ----------------
  logic a_rst_n, a_en, a_pix_tick, a_hsync, a_vsync, a_video_on;
  logic a_line_start, a_frame_start, a_fetch_valid;
  logic [9:0] a_hcount, a_vcount, a_fetch_x, a_fetch_y;
  vga_timing_gen dut_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_en(a_en), .o_pix_tick(a_pix_tick),
    .o_hcount(a_hcount), .o_vcount(a_vcount), .o_hsync(a_hsync), .o_vsync(a_vsync),
    .o_video_on(a_video_on), .o_line_start(a_line_start), .o_frame_start(a_frame_start),
    .o_fetch_x(a_fetch_x), .o_fetch_y(a_fetch_y), .o_fetch_valid(a_fetch_valid));

  // ---------------- DUT B: tiny geometry, CLK_DIV=1 ----------------
  logic b_rst_n, b_en, b_pix_tick, b_hsync, b_vsync, b_video_on;
  logic b_line_start, b_frame_start, b_fetch_valid;
  logic [3:0] b_hcount, b_vcount, b_fetch_x, b_fetch_y;
  vga_timing_gen #(.CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                   .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_en(b_en), .o_pix_tick(b_pix_tick),
    .o_hcount(b_hcount), .o_vcount(b_vcount), .o_hsync(b_hsync), .o_vsync(b_vsync),
    .o_video_on(b_video_on), .o_line_start(b_line_start), .o_frame_start(b_frame_start),
    .o_fetch_x(b_fetch_x), .o_fetch_y(b_fetch_y), .o_fetch_valid(b_fetch_valid));

  // ---------------- DUT C: small geometry, CLK_DIV=2, random stimulus ----------------
  logic c_rst_n, c_en, c_pix_tick, c_hsync, c_vsync, c_video_on;
  logic c_line_start, c_frame_start, c_fetch_valid;
  logic [4:0] c_hcount, c_vcount, c_fetch_x, c_fetch_y;
  vga_timing_gen #(.CLK_DIV(2), .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                   .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CNT_W(5)) dut_c (
    .i_clk(clk), .i_rst_n(c_rst_n), .i_en(c_en), .o_pix_tick(c_pix_tick),
    .o_hcount(c_hcount), .o_vcount(c_vcount), .o_hsync(c_hsync), .o_vsync(c_vsync),
    .o_video_on(c_video_on), .o_line_start(c_line_start), .o_frame_start(c_frame_start),
    .o_fetch_x(c_fetch_x), .o_fetch_y(c_fetch_y), .o_fetch_valid(c_fetch_valid));

  obs_t oa, ob, oc;
  assign oa = {a_pix_tick, a_hcount, a_vcount, a_hsync, a_vsync, a_video_on,
               a_line_start, a_frame_start, a_fetch_x, a_fetch_y, a_fetch_valid};
  assign ob = {b_pix_tick, 6'd0, b_hcount, 6'd0, b_vcount, b_hsync, b_vsync, b_video_on,
               b_line_start, b_frame_start, 6'd0, b_fetch_x, 6'd0, b_fetch_y, b_fetch_valid};
  assign oc = {c_pix_tick, 5'd0, c_hcount, 5'd0, c_vcount, c_hsync, c_vsync, c_video_on,
               c_line_start, c_frame_start, 5'd0, c_fetch_x, 5'd0, c_fetch_y, c_fetch_valid};

  geom_t ga, gb, gc;

  // Reference: the whole state is "enabled cycles since the last clear".
  // Pixel p = c / div ticks have happened; the display shows pixel p-1 of the
  // raster in scan order and the fetch port shows pixel p.
  function automatic obs_t model(int c, geom_t g);
    obs_t o;
    int ht, vt, p, fi, idx, h, v;
    ht = g.hv + g.hf + g.hs + g.hb;
    vt = g.vv + g.vf + g.vs + g.vb;
    o = '0;
    o.hs = ~g.hp;
    o.vs = ~g.vp;
    p  = c / g.div;
    fi = p % (ht * vt);
    o.fx = 10'(fi % ht);
    o.fy = 10'(fi / ht);
    o.fv = (c > 0) && ((fi % ht) < g.hv) && ((fi / ht) < g.vv);
    if (p >= 1) begin
      idx = (p - 1) % (ht * vt);
      h = idx % ht;
      v = idx / ht;
      o.tick = ((c % g.div) == 0);
      o.h   = 10'(h);
      o.v   = 10'(v);
      o.vid = (h < g.hv) && (v < g.vv);
      o.hs  = (h >= g.hv + g.hf && h < g.hv + g.hf + g.hs) ? g.hp : ~g.hp;
      o.vs  = (v >= g.vv + g.vf && v < g.vv + g.vf + g.vs) ? g.vp : ~g.vp;
      o.ls  = o.tick && (h == 0);
      o.fs  = o.ls && (v == 0);
    end
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("tick=%b h=%0d v=%0d hs=%b vs=%b vid=%b ls=%b fs=%b fx=%0d fy=%0d fv=%b",
                     o.tick, o.h, o.v, o.hs, o.vs, o.vid, o.ls, o.fs, o.fx, o.fy, o.fv);
  endfunction

  task automatic check_obs(string nm, obs_t got, obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s @%0t: got {%s} required {%s}", nm, $time, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_int(string nm, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s @%0t: got %0d required %0d", nm, $time, got, exp);
    end
  endtask

  // Enabled-cycle counters that feed the reference model.
  int ca = 0, cb = 0, cc = 0;
  always @(posedge clk or negedge a_rst_n)
    if (!a_rst_n) ca <= 0; else if (!a_en) ca <= 0; else ca <= ca + 1;
  always @(posedge clk or negedge b_rst_n)
    if (!b_rst_n) cb <= 0; else if (!b_en) cb <= 0; else cb <= cb + 1;
  always @(posedge clk or negedge c_rst_n)
    if (!c_rst_n) cc <= 0; else if (!c_en) cc <= 0; else cc <= cc + 1;

  bit mon_on = 1'b0;
  always @(negedge clk) begin
    if (mon_on) begin
      check_obs("model_a", oa, model(ca, ga));
      check_obs("model_b", ob, model(cb, gb));
      check_obs("model_c", oc, model(cc, gc));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  vec_t tv[12];

  initial begin
    ga = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    gb = '{1, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b0};
    gc = '{2, 10, 2, 3, 2, 6, 2, 2, 3, 1'b0, 1'b0};
    //          cyc   h   v   fx  fy tk hs vs vid ls fs fv
    tv[0]  = '{0,    0,  0,  0,  0, 0, 1, 1, 0, 0, 0, 0};
    tv[1]  = '{3,    0,  0,  0,  0, 0, 1, 1, 0, 0, 0, 1};
    tv[2]  = '{4,    0,  0,  1,  0, 1, 1, 1, 1, 1, 1, 1};
    tv[3]  = '{5,    0,  0,  1,  0, 0, 1, 1, 1, 0, 0, 1};
    tv[4]  = '{8,    1,  0,  2,  0, 1, 1, 1, 1, 0, 0, 1};
    tv[5]  = '{2564, 640, 0, 641, 0, 1, 1, 1, 0, 0, 0, 0};
    tv[6]  = '{2627, 655, 0, 656, 0, 0, 1, 1, 0, 0, 0, 0};
    tv[7]  = '{2628, 656, 0, 657, 0, 1, 0, 1, 0, 0, 0, 0};
    tv[8]  = '{3008, 751, 0, 752, 0, 1, 0, 1, 0, 0, 0, 0};
    tv[9]  = '{3012, 752, 0, 753, 0, 1, 1, 1, 0, 0, 0, 0};
    tv[10] = '{3203, 799, 0, 0,   1, 0, 1, 1, 0, 0, 0, 1};
    tv[11] = '{3204, 0,   1, 1,   1, 1, 1, 1, 1, 1, 0, 1};

    a_rst_n = 1'b0; a_en = 1'b0;
    b_rst_n = 1'b0; b_en = 1'b0;
    c_rst_n = 1'b0; c_en = 1'b0;
    repeat (3) @(negedge clk);
    check_obs("reset_a", oa, model(0, ga));
    check_obs("reset_b", ob, model(0, gb));
    check_obs("reset_c", oc, model(0, gc));
    check_int("reset_a_hsync", a_hsync, 1);
    check_int("reset_b_hsync", b_hsync, 0);
    mon_on = 1'b1;

    fork
      // -------- DUT A: table, line timing, enable drop, async reset --------
      begin
        obs_t e;
        int k, lp, hs_lo, vid_n, bad;
        a_en = 1'b1; a_rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
          for (k = 0; k < 5000 && ca < tv[i].cyc; k++) @(negedge clk);
          e = '0;
          e.tick = tv[i].tick; e.h = 10'(tv[i].h); e.v = 10'(tv[i].v);
          e.hs = tv[i].hs; e.vs = tv[i].vs; e.vid = tv[i].vid;
          e.ls = tv[i].ls; e.fs = tv[i].fs;
          e.fx = 10'(tv[i].fx); e.fy = 10'(tv[i].fy); e.fv = tv[i].fv;
          check_obs($sformatf("vec_a[%0d] cyc=%0d", i, tv[i].cyc), oa, e);
        end
        lp = 0; hs_lo = 0; vid_n = 0; bad = 0;
        do begin
          if (!a_hsync) begin
            hs_lo++;
            if (a_hcount < 656 || a_hcount > 751) bad++;
          end
          if (a_video_on) begin
            vid_n++;
            if (a_hcount > 639) bad++;
          end
          lp++;
          @(negedge clk);
        end while (!a_line_start && lp < 4000);
        check_int("line_period", lp, 3200);
        check_int("hsync_width", hs_lo, 384);
        check_int("video_cycles", vid_n, 2560);
        check_int("window_violations", bad, 0);

        for (k = 0; k < 4000 && a_hcount != 700; k++) @(negedge clk);
        check_int("reach_h700", a_hcount, 700);
        check_int("hsync_at_700", a_hsync, 0);
        a_en = 1'b0;
        @(negedge clk);
        check_obs("en_drop", oa, model(0, ga));
        check_int("en_drop_hsync", a_hsync, 1);
        a_en = 1'b1;
        for (k = 1; k <= 10; k++) begin
          @(negedge clk);
          if (a_pix_tick) break;
        end
        check_int("reen_first_tick", k, 4);
        check_int("reen_h", a_hcount, 0);
        check_int("reen_v", a_vcount, 0);
        check_int("reen_frame_start", a_frame_start, 1);

        for (k = 0; k < 4000 && a_hcount != 300; k++) @(negedge clk);
        #2 a_rst_n = 1'b0;
        #1 check_obs("async_rst_a", oa, model(0, ga));
        @(negedge clk);
        a_rst_n = 1'b1;
        for (k = 1; k <= 10; k++) begin
          @(negedge clk);
          if (a_pix_tick) break;
        end
        check_int("rst_a_first_tick", k, 4);
        check_int("rst_a_line_start", a_line_start, 1);
        check_int("rst_a_frame_start", a_frame_start, 1);
      end

      // -------- DUT B: tiny geometry, full-frame property checks --------
      begin
        int last_fs, nfs;
        last_fs = -1; nfs = 0;
        b_en = 1'b1; b_rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          check_int("b_tick", b_pix_tick, 1);
          check_int("b_fetch_x", b_fetch_x, (int'(b_hcount) + 1) % 12);
          check_int("b_hsync", b_hsync, (b_hcount >= 9 && b_hcount <= 10) ? 1 : 0);
          if (b_frame_start) begin
            if (last_fs >= 0) check_int("b_frame_len", cb - last_fs, 84);
            last_fs = cb;
            nfs++;
          end
        end
        check_int("b_frames_seen", nfs, 3);
      end

      // -------- DUT C: async reset inside vsync, then random enable/reset --------
      begin
        int k;
        c_en = 1'b1; c_rst_n = 1'b1;
        for (k = 0; k < 1000 && c_vsync != 1'b0; k++) @(negedge clk);
        check_int("c_reach_vsync", c_vsync, 0);
        repeat (20) @(negedge clk);
        #2 c_rst_n = 1'b0;
        #1 check_obs("async_rst_c", oc, model(0, gc));
        check_int("async_rst_c_vsync", c_vsync, 1);
        @(negedge clk);
        c_rst_n = 1'b1;
        for (k = 1; k <= 10; k++) begin
          @(negedge clk);
          if (c_pix_tick) break;
        end
        check_int("rst_c_first_tick", k, 2);
        check_int("rst_c_frame_start", c_frame_start, 1);
        for (int i = 0; i < 3000; i++) begin
          @(negedge clk);
          c_en = ($urandom_range(0, 999) >= 4);
          if ($urandom_range(0, 499) == 0) begin
            #2 c_rst_n = 1'b0;
            #1 check_obs("c_rand_async", oc, model(0, gc));
            @(negedge clk);
            c_rst_n = 1'b1;
          end
        end
      end
    join

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
